// File: rtl/cpu_pkg.sv
// Shared opcode, ALU and state encodings for the 8-bit CPU controller.
// Also holds the branch-offset helper used by the sequencer.
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam int unsigned PC_INC_DEF = 4;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_TRAP
    } state_t;

    // Word offset in IR[23:16], sign-extended and scaled to bytes.
    function automatic logic [31:0] branch_off(
        input logic [7:0] off
    );
        return {{22{off[7]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode decoder: opcode -> ALU op, operand muxes,
// write enable, branch kind and illegal flag.
module control_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [2:0] aluop,
    output logic       sel_neg,
    output logic       sel_imm,
    output logic       wr_en,
    output logic       is_j,
    output logic       is_beq,
    output logic       illegal
);

    always_comb begin
        aluop   = ALU_FWD;
        sel_neg = 1'b0;
        sel_imm = 1'b0;
        wr_en   = 1'b0;
        is_j    = 1'b0;
        is_beq  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_LOADI: begin
                sel_imm = 1'b1;
                wr_en   = 1'b1;
            end
            OP_MOV: begin
                wr_en = 1'b1;
            end
            OP_ADD: begin
                aluop = ALU_ADD;
                wr_en = 1'b1;
            end
            OP_SUB: begin
                aluop   = ALU_ADD;
                sel_neg = 1'b1;
                wr_en   = 1'b1;
            end
            OP_AND: begin
                aluop = ALU_AND;
                wr_en = 1'b1;
            end
            OP_OR: begin
                aluop = ALU_OR;
                wr_en = 1'b1;
            end
            OP_J: begin
                is_j = 1'b1;
            end
            OP_BEQ: begin
                aluop   = ALU_ADD;
                sel_neg = 1'b1;
                is_beq  = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC controller for the 8-bit CPU datapath.
// Ports: CLK, RESET (async low), PC, IMEM_READ/BUSYWAIT/INSTRUCTION
// fetch handshake, ZERO, ALU/mux/register controls, REG_WRITE, TRAP.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned PC_INC        = PC_INC_DEF,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] PC,
    output logic        IMEM_READ,
    input  logic        IMEM_BUSYWAIT,
    input  logic [31:0] INSTRUCTION,
    input  logic        ZERO,
    output logic [2:0]  ALUOP,
    output logic        SELECT_NEG,
    output logic        SELECT_IMM,
    output logic [2:0]  WRITEREG,
    output logic [2:0]  READREG1,
    output logic [2:0]  READREG2,
    output logic [7:0]  IMMEDIATE,
    output logic        REG_WRITE,
    output logic        TRAP
);

    // Holds 0..FETCH_TIMEOUT-1 stalled cycles.
    localparam int CW = $clog2(FETCH_TIMEOUT + 2);

    state_t        state;
    logic [31:0]   ir;
    logic [CW-1:0] stall_cnt;
    logic          is_j_q;
    logic          is_beq_q;

    logic [2:0] d_aluop;
    logic       d_neg;
    logic       d_imm;
    logic       d_wr;
    logic       d_j;
    logic       d_beq;
    logic       d_ill;

    logic        stall_hit;
    logic        take;
    logic [31:0] pc_seq;
    logic [31:0] pc_tgt;
    logic        unused_ir;

    control_decoder u_dec (
        .opcode  (ir[31:24]),
        .aluop   (d_aluop),
        .sel_neg (d_neg),
        .sel_imm (d_imm),
        .wr_en   (d_wr),
        .is_j    (d_j),
        .is_beq  (d_beq),
        .illegal (d_ill)
    );

    assign WRITEREG  = ir[18:16];
    assign READREG1  = ir[10:8];
    assign READREG2  = ir[2:0];
    assign IMMEDIATE = ir[7:0];
    assign unused_ir = ^ir[15:11];

    // This stalled cycle would be the FETCH_TIMEOUT-th one.
    assign stall_hit = (FETCH_TIMEOUT != 0) &&
                       (32'(stall_cnt) + 32'd1 >= FETCH_TIMEOUT);

    assign take   = is_j_q | (is_beq_q & ZERO);
    assign pc_seq = PC + 32'(PC_INC);
    assign pc_tgt = pc_seq + branch_off(ir[23:16]);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_FETCH;
            PC         <= RESET_PC;
            ir         <= '0;
            stall_cnt  <= '0;
            IMEM_READ  <= 1'b0;
            REG_WRITE  <= 1'b0;
            TRAP       <= 1'b0;
            ALUOP      <= ALU_FWD;
            SELECT_NEG <= 1'b0;
            SELECT_IMM <= 1'b0;
            is_j_q     <= 1'b0;
            is_beq_q   <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!IMEM_READ) begin
                        IMEM_READ <= 1'b1;
                    end else if (!IMEM_BUSYWAIT) begin
                        ir        <= INSTRUCTION;
                        IMEM_READ <= 1'b0;
                        stall_cnt <= '0;
                        state     <= ST_DECODE;
                    end else if (stall_hit) begin
                        IMEM_READ <= 1'b0;
                        TRAP      <= 1'b1;
                        state     <= ST_TRAP;
                    end else begin
                        stall_cnt <= stall_cnt + CW'(1);
                    end
                end
                ST_DECODE: begin
                    if (d_ill) begin
                        TRAP  <= 1'b1;
                        state <= ST_TRAP;
                    end else begin
                        ALUOP      <= d_aluop;
                        SELECT_NEG <= d_neg;
                        SELECT_IMM <= d_imm;
                        REG_WRITE  <= d_wr;
                        is_j_q     <= d_j;
                        is_beq_q   <= d_beq;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    REG_WRITE <= 1'b0;
                    IMEM_READ <= 1'b1;
                    PC        <= take ? pc_tgt : pc_seq;
                    state     <= ST_FETCH;
                end
                ST_TRAP: begin
                    IMEM_READ <= 1'b0;
                    REG_WRITE <= 1'b0;
                end
                default: begin
                    state <= ST_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed vector table,
// hand-written corner sequences and a randomized instruction stream.
module tb_control_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        busy = 1'b0;
    logic        busy2 = 1'b0;
    logic [31:0] INSTRUCTION = '0;
    logic        ZERO = 1'b0;

    logic [31:0] PC, pc2;
    logic        IMEM_READ, rd2;
    logic [2:0]  ALUOP, alu2;
    logic        SELECT_NEG, neg2, SELECT_IMM, imm2;
    logic [2:0]  WRITEREG, READREG1, READREG2;
    logic [2:0]  wreg2, rr12, rr22;
    logic [7:0]  IMMEDIATE, immv2;
    logic        REG_WRITE, rw2, TRAP, trap2;

    always #5 CLK = ~CLK;

    control_sequencer dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .PC            (PC),
        .IMEM_READ     (IMEM_READ),
        .IMEM_BUSYWAIT (busy),
        .INSTRUCTION   (INSTRUCTION),
        .ZERO          (ZERO),
        .ALUOP         (ALUOP),
        .SELECT_NEG    (SELECT_NEG),
        .SELECT_IMM    (SELECT_IMM),
        .WRITEREG      (WRITEREG),
        .READREG1      (READREG1),
        .READREG2      (READREG2),
        .IMMEDIATE     (IMMEDIATE),
        .REG_WRITE     (REG_WRITE),
        .TRAP          (TRAP)
    );

    control_sequencer #(
        .RESET_PC      (32'hFFFF_FFFC),
        .FETCH_TIMEOUT (3)
    ) dut2 (
        .CLK           (CLK),
        .RESET         (RESET),
        .PC            (pc2),
        .IMEM_READ     (rd2),
        .IMEM_BUSYWAIT (busy2),
        .INSTRUCTION   (INSTRUCTION),
        .ZERO          (ZERO),
        .ALUOP         (alu2),
        .SELECT_NEG    (neg2),
        .SELECT_IMM    (imm2),
        .WRITEREG      (wreg2),
        .READREG1      (rr12),
        .READREG2      (rr22),
        .IMMEDIATE     (immv2),
        .REG_WRITE     (rw2),
        .TRAP          (trap2)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_wr = -1;
    logic [31:0] mpc = '0;
    logic [31:0] cur_ir = '0;

    always @(posedge CLK) cyc++;

    typedef struct {
        logic [31:0] ins;
        logic        z;
        int          st;
        logic        ck;
        logic [2:0]  alu;
        logic        neg;
        logic        imm;
        logic        wr;
        logic [31:0] npc;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        busy  = 1'b0;
        busy2 = 1'b0;
        ZERO  = 1'b0;
        @(negedge CLK);
        RESET  = 1'b1;
        cyc    = 0;
        mpc    = '0;
        cur_ir = '0;
        @(negedge CLK);
    endtask

    task automatic do_instr(input logic [31:0] ins, input logic z,
                            input int st, input logic ck,
                            input logic [2:0] ealu,
                            input logic eneg, input logic eimm,
                            input logic ewr, input logic [31:0] npc);
        chk("pc_fetch", PC, mpc);
        chk("rd_fetch", IMEM_READ, 1);
        for (int i = 0; i < st; i++) begin
            busy = 1'b1;
            INSTRUCTION = $urandom;
            @(negedge CLK);
            chk("rd_stall", IMEM_READ, 1);
            chk("ir_hold", {WRITEREG, IMMEDIATE},
                {cur_ir[18:16], cur_ir[7:0]});
        end
        busy = 1'b0;
        INSTRUCTION = ins;
        @(negedge CLK);
        chk("rd_drop", IMEM_READ, 0);
        cur_ir = ins;
        INSTRUCTION = $urandom;
        busy = 1'($urandom);
        @(negedge CLK);
        if (ck) begin
            chk("aluop", ALUOP, ealu);
            chk("sel_neg", SELECT_NEG, eneg);
            chk("sel_imm", SELECT_IMM, eimm);
        end
        chk("rw_exec", REG_WRITE, ewr);
        if (REG_WRITE) last_wr = cyc;
        chk("wreg", WRITEREG, ins[18:16]);
        chk("rreg1", READREG1, ins[10:8]);
        chk("rreg2", READREG2, ins[2:0]);
        chk("immed", IMMEDIATE, ins[7:0]);
        chk("trap_exec", TRAP, 0);
        ZERO = z;
        busy = 1'($urandom);
        @(negedge CLK);
        chk("rw_clear", REG_WRITE, 0);
        chk("pc_next", PC, npc);
        mpc = npc;
    endtask

    logic [2:0]  alut[8];
    logic [31:0] r;
    logic [7:0]  op;
    logic signed [7:0] soff;
    logic [31:0] enpc;
    logic        zr;

    initial begin
        alut = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
        vt[0]  = '{32'h0001_0005, 0, 0, 1, 3'd0, 0, 1, 1, 32'd4};
        vt[1]  = '{32'h0104_0200, 0, 0, 1, 3'd0, 0, 0, 1, 32'd8};
        vt[2]  = '{32'h0205_0102, 0, 4, 1, 3'd1, 0, 0, 1, 32'd12};
        vt[3]  = '{32'h0506_0304, 0, 0, 1, 3'd3, 0, 0, 1, 32'd16};
        vt[4]  = '{32'h06FE_0000, 0, 0, 0, 3'd0, 0, 0, 0, 32'd12};
        vt[5]  = '{32'h0407_0506, 0, 1, 1, 3'd2, 0, 0, 1, 32'd16};
        vt[6]  = '{32'h0000_00FF, 0, 0, 1, 3'd0, 0, 1, 1, 32'd20};
        vt[7]  = '{32'h0702_0102, 1, 0, 1, 3'd1, 1, 0, 0, 32'd32};
        vt[8]  = '{32'h06FC_0000, 0, 0, 0, 3'd0, 0, 0, 0, 32'd20};
        vt[9]  = '{32'h0702_0102, 0, 0, 1, 3'd1, 1, 0, 0, 32'd24};
        vt[10] = '{32'h0301_0203, 0, 2, 1, 3'd1, 1, 0, 1, 32'd28};
        vt[11] = '{32'h0780_0000, 1, 0, 1, 3'd1, 1, 0, 0,
                   32'hFFFF_FE20};
        vt[12] = '{32'h067F_0000, 0, 0, 0, 3'd0, 0, 0, 0, 32'h20};

        // Reset values while held
        @(negedge CLK);
        chk("rst_pc", PC, 0);
        chk("rst_rd", IMEM_READ, 0);
        chk("rst_rw", REG_WRITE, 0);
        chk("rst_trap", TRAP, 0);
        chk("rst_alu", {ALUOP, SELECT_NEG, SELECT_IMM}, 0);

        // Reset in the middle of an add's EXEC cycle
        do_reset();
        do_instr(32'h0001_0005, 0, 0, 1, 3'd0, 0, 1, 1, 32'd4);
        busy = 1'b0;
        INSTRUCTION = 32'h0201_0203;
        @(negedge CLK);
        @(negedge CLK);
        chk("mid_rw", REG_WRITE, 1);
        chk("mid_pc", PC, 4);
        #2 RESET = 1'b0;
        #1;
        chk("arst_rw", REG_WRITE, 0);
        chk("arst_rd", IMEM_READ, 0);
        chk("arst_pc", PC, 0);
        chk("arst_ir", {WRITEREG, IMMEDIATE}, 0);
        @(negedge CLK);
        RESET = 1'b1;
        cyc = 0;
        mpc = '0;
        cur_ir = '0;
        chk("rel_rd", IMEM_READ, 0);
        @(negedge CLK);
        chk("rel_rd1", IMEM_READ, 1);
        chk("rel_pc", PC, 0);

        // Zero-wait stream: write pulses on cycles 3, 6, 9
        do_reset();
        do_instr(32'h0001_0005, 0, 0, 1, 3'd0, 0, 1, 1, 32'd4);
        chk("wr_cyc1", last_wr, 3);
        do_instr(32'h0002_0003, 0, 0, 1, 3'd0, 0, 1, 1, 32'd8);
        chk("wr_cyc2", last_wr, 6);
        do_instr(32'h0303_0102, 0, 0, 1, 3'd1, 1, 0, 1, 32'd12);
        chk("wr_cyc3", last_wr, 9);

        // Directed vector table
        do_reset();
        for (int i = 0; i < 13; i++) begin
            do_instr(vt[i].ins, vt[i].z, vt[i].st, vt[i].ck,
                     vt[i].alu, vt[i].neg, vt[i].imm, vt[i].wr,
                     vt[i].npc);
        end

        // Illegal opcode traps and holds until reset
        do_reset();
        do_instr(32'h0001_0005, 0, 0, 1, 3'd0, 0, 1, 1, 32'd4);
        busy = 1'b0;
        INSTRUCTION = 32'h0800_0000;
        @(negedge CLK);
        @(negedge CLK);
        chk("ill_trap", TRAP, 1);
        chk("ill_pc", PC, 4);
        for (int i = 0; i < 5; i++) begin
            busy = 1'($urandom);
            INSTRUCTION = $urandom;
            ZERO = 1'($urandom);
            @(negedge CLK);
            chk("trap_hold", {TRAP, IMEM_READ, REG_WRITE}, 3'b100);
            chk("trap_pc", PC, 4);
        end

        // PC wrap then fetch timeout on the second instance
        do_reset();
        chk("w_pc0", pc2, 32'hFFFF_FFFC);
        chk("w_rd0", rd2, 1);
        INSTRUCTION = 32'h0201_0203;
        @(negedge CLK);
        @(negedge CLK);
        chk("w_alu", alu2, 3'd1);
        chk("w_rw", rw2, 1);
        busy2 = 1'b1;
        @(negedge CLK);
        chk("w_pc", pc2, 0);
        chk("w_rd", rd2, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("to_early", {trap2, rd2}, 2'b01);
        end
        @(negedge CLK);
        chk("to_trap", {trap2, rd2}, 2'b10);
        chk("to_pc", pc2, 0);

        // Randomized stream against the reference model
        do_reset();
        for (int n = 0; n < 80; n++) begin
            r    = $urandom;
            op   = 8'($urandom_range(0, 7));
            zr   = 1'($urandom);
            soff = $signed(r[23:16]);
            enpc = mpc + 32'd4;
            if (op == 8'd6 || (op == 8'd7 && zr))
                enpc = enpc + 32'(int'(soff) * 4);
            do_instr({op, r[23:0]}, zr, int'($urandom_range(0, 3)),
                     op != 8'd6, alut[op[2:0]],
                     op == 8'd3 || op == 8'd7, op == 8'd0,
                     op < 8'd6, enpc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
